// File: rtl/alien_rocket_pkg.sv
// Shared screen geometry, rocket dimensions and launcher FSM encodings
// for the alien rocket block.
package alien_rocket_pkg;

    localparam int SCREEN_W  = 640;
    localparam int SCREEN_H  = 480;
    localparam int ROCKET_HW = 2;
    localparam int ROCKET_H  = 4;

    typedef enum logic [1:0] {
        COOL = 2'd0,
        ARM  = 2'd1,
        FLY  = 2'd2
    } state_e;

    // Unsigned subtraction that floors at zero instead of wrapping.
    function automatic logic [10:0] sub_floor0(input logic [10:0] a, input logic [10:0] b);
        return (a > b) ? (a - b) : 11'd0;
    endfunction

endpackage

// File: rtl/alien_rocket_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), free-running from reset.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] q
);

    // Shift register advances on every clock once out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= SEED;
        end else begin
            q <= {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
        end
    end

endmodule

// File: rtl/alien_rocket.sv
// Alien rocket launcher: picks a live column, drops one rocket per frame tick,
// and flags collisions with the player's ship.
module alien_rocket
    import alien_rocket_pkg::*;
#(
    parameter int          NCOLS     = 8,
    parameter int          COL_PITCH = 40,
    parameter int          ROW_DROP  = 16,
    parameter int          SPEED     = 3,
    parameter int          COOLDOWN  = 60,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             playing,
    input  logic             tick,
    input  logic [9:0]       formX,
    input  logic [8:0]       formY,
    input  logic [NCOLS-1:0] col_alive,
    input  logic [9:0]       shipX,
    input  logic [8:0]       shipY,
    input  logic [5:0]       shipborderX,
    input  logic [4:0]       shipborderY,
    output logic             alienrocket1,
    output logic [9:0]       alienrocket1X,
    output logic [8:0]       alienrocket1Y,
    output logic             shiphit
);

    localparam int CW = $clog2(NCOLS);
    localparam int TW = $clog2(COOLDOWN + 1);

    state_e        state_r, state_n;
    logic [TW-1:0] timer_r, timer_n;
    logic [9:0]    x_r, x_n;
    logic [8:0]    y_r, y_n;
    logic          live_r, live_n;
    logic          hit_r, hit_n;

    logic [15:0]   lfsr_q;
    logic [CW-1:0] col_s;
    logic          lfsr_unused_s;
    logic [10:0]   spawn_x_s, spawn_y_s;
    logic [10:0]   ship_x_lo_s, ship_x_hi_s, ship_y_lo_s, ship_y_hi_s;
    logic          hit_s, off_s;

    lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (lfsr_q)
    );

    assign col_s         = lfsr_q[CW-1:0];
    assign lfsr_unused_s = ^lfsr_q[15:CW];

    assign spawn_x_s = 11'(formX) + 11'(col_s) * 11'(COL_PITCH);
    assign spawn_y_s = 11'(formY) + 11'(ROW_DROP);

    // Bounding-box overlap between the 4x4 rocket and the ship, evaluated on registered X/Y.
    assign ship_x_lo_s = sub_floor0(11'(shipX), 11'(shipborderX));
    assign ship_x_hi_s = 11'(shipX) + 11'(shipborderX);
    assign ship_y_lo_s = sub_floor0(11'(shipY), 11'(shipborderY));
    assign ship_y_hi_s = 11'(shipY) + 11'(shipborderY);

    assign hit_s = (sub_floor0(11'(x_r), 11'(ROCKET_HW)) <= ship_x_hi_s) &&
                   ((11'(x_r) + 11'(ROCKET_HW)) >= ship_x_lo_s) &&
                   ((11'(y_r) + 11'(ROCKET_H)) >= ship_y_lo_s) &&
                   (11'(y_r) <= ship_y_hi_s);
    assign off_s = (11'(y_r) + 11'(SPEED)) >= 11'(SCREEN_H);

    // Next-state and next-output logic for the launcher.
    always_comb begin
        state_n = state_r;
        timer_n = timer_r;
        x_n     = x_r;
        y_n     = y_r;
        live_n  = live_r;
        hit_n   = 1'b0;
        if (!playing) begin
            state_n = COOL;
            timer_n = TW'(COOLDOWN);
            x_n     = 10'd0;
            y_n     = 9'd0;
            live_n  = 1'b0;
        end else if (tick) begin
            case (state_r)
                COOL: begin
                    if (timer_r <= TW'(1)) begin
                        timer_n = TW'(0);
                        state_n = ARM;
                    end else begin
                        timer_n = timer_r - TW'(1);
                    end
                end
                ARM: begin
                    if (col_alive[col_s]) begin
                        x_n     = (spawn_x_s > 11'(SCREEN_W - 1)) ? 10'(SCREEN_W - 1) : spawn_x_s[9:0];
                        y_n     = (spawn_y_s > 11'd511) ? 9'd511 : spawn_y_s[8:0];
                        live_n  = 1'b1;
                        state_n = FLY;
                    end else begin
                        state_n = ARM;
                    end
                end
                FLY: begin
                    if (hit_s || off_s) begin
                        hit_n   = hit_s;
                        live_n  = 1'b0;
                        x_n     = 10'd0;
                        y_n     = 9'd0;
                        timer_n = TW'(COOLDOWN);
                        state_n = COOL;
                    end else begin
                        y_n = y_r + 9'(SPEED);
                    end
                end
                default: begin
                    live_n  = 1'b0;
                    x_n     = 10'd0;
                    y_n     = 9'd0;
                    timer_n = TW'(COOLDOWN);
                    state_n = COOL;
                end
            endcase
        end else begin
            state_n = state_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= COOL;
            timer_r <= TW'(COOLDOWN);
            x_r     <= 10'd0;
            y_r     <= 9'd0;
            live_r  <= 1'b0;
            hit_r   <= 1'b0;
        end else begin
            state_r <= state_n;
            timer_r <= timer_n;
            x_r     <= x_n;
            y_r     <= y_n;
            live_r  <= live_n;
            hit_r   <= hit_n;
        end
    end

    assign alienrocket1  = live_r;
    assign alienrocket1X = x_r;
    assign alienrocket1Y = y_r;
    assign shiphit       = hit_r;

endmodule
